id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS core. Sits directly downstream of the opcode control decoder and register file.
- Latches the decoder's EX/MEM/WB control bits plus operand data each cycle and presents them to the EX stage.
- Detects load-use hazards, inserts bubbles, drives the stall to PC and IF/ID, and supports external hold and flush.

Parameters:
- DATA_W, 32, operand/immediate width
- REG_AW, 5, register address width
- CNT_W, 16, bubble counter width (used only with the optional feature)

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-low
- Hold_i  in  1  global freeze (memory stall); all registers keep their values
- Flush_i  in  1  discard the instruction currently in ID; load a bubble
- RegDst_i, ALUSrc_i, RegWrite_i, MemWrite_i, MemRead_i, MemtoReg_i  in  1 each  control bits from the decoder
- ALUOp_i  in  2  ALU op class from the decoder
- RSdata_i, RTdata_i, SignExt_i  in  DATA_W each  register operands and sign-extended immediate
- RSaddr_i, RTaddr_i, RDaddr_i  in  REG_AW each  instruction fields [25:21], [20:16], [15:11]
- Funct_i  in  6  instruction field [5:0]
- RegDst_o, ALUSrc_o, RegWrite_o, MemWrite_o, MemRead_o, MemtoReg_o  out  1 each  registered control bits
- ALUOp_o  out  2  registered ALU op class
- RSdata_o, RTdata_o, SignExt_o  out  DATA_W each  registered data
- RSaddr_o, RTaddr_o, RDaddr_o  out  REG_AW each  registered addresses
- Funct_o  out  6  registered funct field
- Valid_o  out  1  1 = real instruction in EX; 0 = bubble
- Stall_o  out  1  combinational; deasserts PC write and IF/ID write

Behaviour:
- Reset (rst_i=0 at a clock edge): every output register, including Valid_o, clears to 0. Reset overrides all other inputs. The core leaves reset holding a bubble.
- Hazard: hz = MemRead_o & (RTaddr_o != 0) & ((RTaddr_o == RSaddr_i) | (RTaddr_o == RTaddr_i)).
- Stall_o = hz & ~Flush_i & ~Hold_i. Stall_o is purely combinational from the registered outputs and inputs, with no registered delay.
- Per-edge priority, highest first:
  1. Reset: clear everything.
  2. Hold_i=1: all registers unchanged; Stall_o=0.
  3. Flush_i=1: load a bubble.
  4. hz=1: load a bubble.
  5. Otherwise capture all inputs and set Valid_o=1.
- Bubble:
  - All seven control outputs become 0 and Valid_o becomes 0.
  - Data, address and Funct registers still capture their inputs.
  - Consequence: MemRead_o drops to 0, so a load-use stall lasts exactly one cycle.
- Latency: 1 cycle from input to output. No combinational path from any _i to any registered _o.
- Back-to-back loads: the second load stalls only if it depends on the first; there is no extra penalty otherwise.
- Flush during hazard: the bubble is loaded, Stall_o=0, and the stalled instruction is discarded.
- Reset during stall: the next cycle after reset has Stall_o=0 because MemRead_o=0.

Optional Feature:
- Macro: ID_EX_BUBBLE_CNT_EN.
- Enabled:
  - Adds output BubbleCnt_o, CNT_W wide.
  - Resets to 0.
  - Increments by 1 on each edge where a bubble is loaded due to Flush_i or hz. It does not increment during Hold_i or reset.
  - Wraps from 2^CNT_W-1 to 0.
- Disabled: port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset: rst_i=0 for 2 cycles with all inputs at 1 -> all outputs 0, Valid_o=0, Stall_o=0; after release, first captured instruction appears 1 cycle later with Valid_o=1.
2. Load-use: lw $8 in EX (MemRead_o=1, RTaddr_o=8) with ID RSaddr_i=8 -> Stall_o=1 that cycle; next cycle all control outputs 0 and Valid_o=0, Stall_o=0; following cycle the dependent add is captured with RegDst_o=1, ALUOp_o=2'b10.
3. No false hazard: RTaddr_o=0 with MemRead_o=1 and RSaddr_i=0 -> Stall_o=0. Also lw $9 with independent ID operands (rs=3, rt=4) -> Stall_o=0.
4. Hold: Hold_i=1 for 3 cycles with changing inputs -> outputs frozen, Stall_o=0 even while a hazard exists; on release the hazard asserts Stall_o in that cycle.
5. Flush vs hazard: Flush_i=1 together with hz=1 -> Stall_o=0, bubble loaded. Flush_i=1 with sw in ID -> MemWrite_o=0 next cycle.
6. With ID_EX_BUBBLE_CNT_EN and CNT_W=4: 17 bubbles -> BubbleCnt_o=1 (wrap from 15 to 0 observed). Holds and normal captures leave the count unchanged.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion, hold and flush.
// Optional bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              Hold_i,
   input  logic              Flush_i,
   input  logic              RegDst_i,
   input  logic              ALUSrc_i,
   input  logic              RegWrite_i,
   input  logic              MemWrite_i,
   input  logic              MemRead_i,
   input  logic              MemtoReg_i,
   input  logic [1:0]        ALUOp_i,
   input  logic [DATA_W-1:0] RSdata_i,
   input  logic [DATA_W-1:0] RTdata_i,
   input  logic [DATA_W-1:0] SignExt_i,
   input  logic [REG_AW-1:0] RSaddr_i,
   input  logic [REG_AW-1:0] RTaddr_i,
   input  logic [REG_AW-1:0] RDaddr_i,
   input  logic [5:0]        Funct_i,
   output logic              RegDst_o,
   output logic              ALUSrc_o,
   output logic              RegWrite_o,
   output logic              MemWrite_o,
   output logic              MemRead_o,
   output logic              MemtoReg_o,
   output logic [1:0]        ALUOp_o,
   output logic [DATA_W-1:0] RSdata_o,
   output logic [DATA_W-1:0] RTdata_o,
   output logic [DATA_W-1:0] SignExt_o,
   output logic [REG_AW-1:0] RSaddr_o,
   output logic [REG_AW-1:0] RTaddr_o,
   output logic [REG_AW-1:0] RDaddr_o,
   output logic [5:0]        Funct_o,
   output logic              Valid_o,
   output logic              Stall_o
`ifdef ID_EX_BUBBLE_CNT_EN
   ,
   output logic [CNT_W-1:0]  BubbleCnt_o
`endif
);

   logic hz;
   logic bubble;

   // A load in EX whose destination feeds the instruction in ID must wait one cycle.
   assign hz     = MemRead_o & (RTaddr_o != '0) &
                   ((RTaddr_o == RSaddr_i) | (RTaddr_o == RTaddr_i));
   assign bubble = Flush_i | hz;
   assign Stall_o = hz & ~Flush_i & ~Hold_i;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         RegDst_o   <= 1'b0;
         ALUSrc_o   <= 1'b0;
         RegWrite_o <= 1'b0;
         MemWrite_o <= 1'b0;
         MemRead_o  <= 1'b0;
         MemtoReg_o <= 1'b0;
         ALUOp_o    <= 2'b00;
         RSdata_o   <= '0;
         RTdata_o   <= '0;
         SignExt_o  <= '0;
         RSaddr_o   <= '0;
         RTaddr_o   <= '0;
         RDaddr_o   <= '0;
         Funct_o    <= '0;
         Valid_o    <= 1'b0;
      end else if (!Hold_i) begin
         // Operand fields move on even for a bubble; only control and Valid are squashed.
         RSdata_o  <= RSdata_i;
         RTdata_o  <= RTdata_i;
         SignExt_o <= SignExt_i;
         RSaddr_o  <= RSaddr_i;
         RTaddr_o  <= RTaddr_i;
         RDaddr_o  <= RDaddr_i;
         Funct_o   <= Funct_i;
         if (bubble) begin
            RegDst_o   <= 1'b0;
            ALUSrc_o   <= 1'b0;
            RegWrite_o <= 1'b0;
            MemWrite_o <= 1'b0;
            MemRead_o  <= 1'b0;
            MemtoReg_o <= 1'b0;
            ALUOp_o    <= 2'b00;
            Valid_o    <= 1'b0;
         end else begin
            RegDst_o   <= RegDst_i;
            ALUSrc_o   <= ALUSrc_i;
            RegWrite_o <= RegWrite_i;
            MemWrite_o <= MemWrite_i;
            MemRead_o  <= MemRead_i;
            MemtoReg_o <= MemtoReg_i;
            ALUOp_o    <= ALUOp_i;
            Valid_o    <= 1'b1;
         end
      end
   end

`ifdef ID_EX_BUBBLE_CNT_EN
   // Counts inserted bubbles (flush or load-use); wraps naturally at the counter width.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         BubbleCnt_o <= '0;
      end else if (!Hold_i && bubble) begin
         BubbleCnt_o <= BubbleCnt_o + 1'b1;
      end
   end
`else
   logic [CNT_W-1:0] unused_cnt;
   assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push expected outputs, a monitor pops and compares.
// Define ID_EX_BUBBLE_CNT_EN to also exercise the 4-bit bubble counter.
module tb_id_ex_stage;

`ifdef ID_EX_BUBBLE_CNT_EN
   localparam int TB_CNT_W = 4;
`else
   localparam int TB_CNT_W = 16;
`endif

   typedef struct packed {
      logic [7:0]  ctrl;   // {RegDst, ALUSrc, RegWrite, MemWrite, MemRead, MemtoReg, ALUOp[1:0]}
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] imm;
      logic [4:0]  rsa;
      logic [4:0]  rta;
      logic [4:0]  rda;
      logic [5:0]  funct;
   } instr_t;

   typedef struct packed {
      instr_t      ins;
      logic        valid;
      logic [15:0] cnt;
   } exp_t;

   logic clk_i = 1'b0;
   logic rst_i, Hold_i, Flush_i;
   logic RegDst_i, ALUSrc_i, RegWrite_i, MemWrite_i, MemRead_i, MemtoReg_i;
   logic [1:0] ALUOp_i;
   logic [31:0] RSdata_i, RTdata_i, SignExt_i;
   logic [4:0] RSaddr_i, RTaddr_i, RDaddr_i;
   logic [5:0] Funct_i;
   logic RegDst_o, ALUSrc_o, RegWrite_o, MemWrite_o, MemRead_o, MemtoReg_o;
   logic [1:0] ALUOp_o;
   logic [31:0] RSdata_o, RTdata_o, SignExt_o;
   logic [4:0] RSaddr_o, RTaddr_o, RDaddr_o;
   logic [5:0] Funct_o;
   logic Valid_o, Stall_o;
`ifdef ID_EX_BUBBLE_CNT_EN
   logic [TB_CNT_W-1:0] BubbleCnt_o;
`endif

   int tests = 0;
   int fails = 0;
   int exp_cnt = 0;
   exp_t  exp_q[$];
   string name_q[$];

   id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(TB_CNT_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .Hold_i(Hold_i), .Flush_i(Flush_i),
      .RegDst_i(RegDst_i), .ALUSrc_i(ALUSrc_i), .RegWrite_i(RegWrite_i),
      .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i), .MemtoReg_i(MemtoReg_i),
      .ALUOp_i(ALUOp_i), .RSdata_i(RSdata_i), .RTdata_i(RTdata_i), .SignExt_i(SignExt_i),
      .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i), .Funct_i(Funct_i),
      .RegDst_o(RegDst_o), .ALUSrc_o(ALUSrc_o), .RegWrite_o(RegWrite_o),
      .MemWrite_o(MemWrite_o), .MemRead_o(MemRead_o), .MemtoReg_o(MemtoReg_o),
      .ALUOp_o(ALUOp_o), .RSdata_o(RSdata_o), .RTdata_o(RTdata_o), .SignExt_o(SignExt_o),
      .RSaddr_o(RSaddr_o), .RTaddr_o(RTaddr_o), .RDaddr_o(RDaddr_o), .Funct_o(Funct_o),
      .Valid_o(Valid_o), .Stall_o(Stall_o)
`ifdef ID_EX_BUBBLE_CNT_EN
      , .BubbleCnt_o(BubbleCnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   function automatic instr_t mk_instr(input logic [7:0] ctrl, input logic [31:0] rs, rt, imm,
                                       input logic [4:0] rsa, rta, rda, input logic [5:0] funct);
      instr_t r;
      r.ctrl = ctrl; r.rs = rs; r.rt = rt; r.imm = imm;
      r.rsa = rsa; r.rta = rta; r.rda = rda; r.funct = funct;
      return r;
   endfunction

   // Expected EX contents when the instruction is captured normally.
   function automatic exp_t cap(input instr_t in);
      exp_t e;
      e.ins = in; e.valid = 1'b1; e.cnt = '0;
      return e;
   endfunction

   // Expected EX contents when a bubble is loaded over the instruction.
   function automatic exp_t bub(input instr_t in);
      exp_t e;
      e.ins = in; e.ins.ctrl = 8'h00; e.valid = 1'b0; e.cnt = '0;
      return e;
   endfunction

   task automatic applyStimulus(input instr_t in, input logic rst, hold, flush, exp_stall,
                                input exp_t exp_out, input string name);
      @(posedge clk_i);
      #3;
      rst_i = rst; Hold_i = hold; Flush_i = flush;
      {RegDst_i, ALUSrc_i, RegWrite_i, MemWrite_i, MemRead_i, MemtoReg_i, ALUOp_i} = in.ctrl;
      RSdata_i = in.rs; RTdata_i = in.rt; SignExt_i = in.imm;
      RSaddr_i = in.rsa; RTaddr_i = in.rta; RDaddr_i = in.rda; Funct_i = in.funct;
      #1;
      tests++;
      if (Stall_o !== exp_stall) begin
         fails++;
         $display("[TB] FAIL %s stall: got %b expected %b", name, Stall_o, exp_stall);
      end
      if (!rst) exp_cnt = 0;
      else if (!hold && !exp_out.valid) exp_cnt = (exp_cnt + 1) % (1 << TB_CNT_W);
      exp_out.cnt = 16'(exp_cnt);
      exp_q.push_back(exp_out);
      name_q.push_back(name);
   endtask

   task automatic checkOutput(input exp_t e, input string name);
      exp_t act;
      act.ins.ctrl  = {RegDst_o, ALUSrc_o, RegWrite_o, MemWrite_o, MemRead_o, MemtoReg_o, ALUOp_o};
      act.ins.rs    = RSdata_o;  act.ins.rt  = RTdata_o;  act.ins.imm = SignExt_o;
      act.ins.rsa   = RSaddr_o;  act.ins.rta = RTaddr_o;  act.ins.rda = RDaddr_o;
      act.ins.funct = Funct_o;
      act.valid     = Valid_o;
      act.cnt       = '0;
      tests++;
      if ({act.ins, act.valid} !== {e.ins, e.valid}) begin
         fails++;
         $display("[TB] FAIL %s outputs: got %h expected %h", name, {act.ins, act.valid}, {e.ins, e.valid});
      end
`ifdef ID_EX_BUBBLE_CNT_EN
      tests++;
      if (BubbleCnt_o !== e.cnt[TB_CNT_W-1:0]) begin
         fails++;
         $display("[TB] FAIL %s bubble_cnt: got %0d expected %0d", name, BubbleCnt_o, e.cnt);
      end
`endif
   endtask

   // Monitor: one registered result per clock, compared against the oldest expectation.
   initial begin
      exp_t  e;
      string nm;
      forever begin
         @(posedge clk_i);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checkOutput(e, nm);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      instr_t all1, lw8, add8, lw0, nopz, lw9, add_ind, lw_dep, dep9, sw, sw8;
      exp_t   zero_exp;
      all1    = '1;
      lw8     = mk_instr(8'b01101100, 32'h0000_0100, 32'h0000_0055, 32'h0000_0004, 5'd2, 5'd8, 5'd0, 6'h04);
      add8    = mk_instr(8'b10100010, 32'h0000_0011, 32'h0000_0022, 32'h0000_5020, 5'd8, 5'd3, 5'd10, 6'h20);
      lw0     = mk_instr(8'b01101100, 32'h0000_0200, 32'h0000_0000, 32'h0000_0008, 5'd1, 5'd0, 5'd0, 6'h08);
      nopz    = '0;
      lw9     = mk_instr(8'b01101100, 32'h0000_0300, 32'h0000_0066, 32'h0000_000C, 5'd2, 5'd9, 5'd0, 6'h0C);
      add_ind = mk_instr(8'b10100010, 32'h0000_0033, 32'h0000_0044, 32'h0000_2820, 5'd3, 5'd4, 5'd5, 6'h20);
      lw_dep  = mk_instr(8'b01101100, 32'h0000_0400, 32'h0000_0077, 32'h0000_0010, 5'd8, 5'd5, 5'd0, 6'h10);
      dep9    = mk_instr(8'b10100010, 32'h0000_0099, 32'h0000_0044, 32'h0000_5820, 5'd9, 5'd4, 5'd11, 6'h20);
      sw      = mk_instr(8'b01010000, 32'h0000_0500, 32'h0000_00AA, 32'h0000_0014, 5'd2, 5'd6, 5'd0, 6'h14);
      sw8     = mk_instr(8'b01010000, 32'h0000_0600, 32'h0000_00BB, 32'h0000_0018, 5'd1, 5'd8, 5'd0, 6'h18);
      zero_exp = '0;

      // Reset asserted from time zero with every other input at 1.
      rst_i = 1'b0; Hold_i = 1'b1; Flush_i = 1'b1;
      {RegDst_i, ALUSrc_i, RegWrite_i, MemWrite_i, MemRead_i, MemtoReg_i, ALUOp_i} = 8'hFF;
      RSdata_i = '1; RTdata_i = '1; SignExt_i = '1;
      RSaddr_i = '1; RTaddr_i = '1; RDaddr_i = '1; Funct_i = '1;

      applyStimulus(all1,    0, 1, 1, 0, zero_exp,     "reset_a");
      applyStimulus(all1,    0, 1, 1, 0, zero_exp,     "reset_b");
      applyStimulus(lw8,     1, 0, 0, 0, cap(lw8),     "first_capture_lw8");
      applyStimulus(add8,    1, 0, 0, 1, bub(add8),    "load_use_stall");
      applyStimulus(add8,    1, 0, 0, 0, cap(add8),    "dependent_add");
      applyStimulus(lw0,     1, 0, 0, 0, cap(lw0),     "lw_r0");
      applyStimulus(nopz,    1, 0, 0, 0, cap(nopz),    "r0_no_hazard");
      applyStimulus(lw9,     1, 0, 0, 0, cap(lw9),     "lw9");
      applyStimulus(add_ind, 1, 0, 0, 0, cap(add_ind), "lw9_independent");
      applyStimulus(lw8,     1, 0, 0, 0, cap(lw8),     "lw8_again");
      applyStimulus(lw_dep,  1, 0, 0, 1, bub(lw_dep),  "dep_load_stall");
      applyStimulus(lw_dep,  1, 0, 0, 0, cap(lw_dep),  "dep_load_capture");
      applyStimulus(lw9,     1, 0, 0, 0, cap(lw9),     "b2b_load_no_penalty");
      applyStimulus(dep9,    1, 1, 0, 0, cap(lw9),     "hold_1");
      applyStimulus(sw,      1, 1, 0, 0, cap(lw9),     "hold_2");
      applyStimulus(dep9,    1, 1, 0, 0, cap(lw9),     "hold_3");
      applyStimulus(dep9,    1, 0, 0, 1, bub(dep9),    "hold_release_stall");
      applyStimulus(dep9,    1, 0, 0, 0, cap(dep9),    "dep9_capture");
      applyStimulus(lw8,     1, 0, 0, 0, cap(lw8),     "lw8_pre_flush");
      applyStimulus(add8,    1, 0, 1, 0, bub(add8),    "flush_over_hazard");
      applyStimulus(sw,      1, 0, 1, 0, bub(sw),      "flush_sw");
      applyStimulus(sw,      1, 0, 0, 0, cap(sw),      "sw_capture");
      applyStimulus(lw8,     1, 0, 0, 0, cap(lw8),     "lw8_pre_reset");
      applyStimulus(add8,    0, 0, 0, 1, zero_exp,     "reset_during_stall");
      applyStimulus(add8,    1, 0, 0, 0, cap(add8),    "after_reset_no_stall");
      applyStimulus(lw8,     1, 0, 0, 0, cap(lw8),     "lw8_rt_test");
      applyStimulus(sw8,     1, 0, 0, 1, bub(sw8),     "rt_match_stall");
      applyStimulus(sw8,     1, 0, 0, 0, cap(sw8),     "sw8_capture");
      for (int i = 0; i < 16; i++) begin
         applyStimulus(nopz, 1, 0, 1, 0, bub(nopz),    "flush_bubble");
      end
      applyStimulus(add_ind, 1, 1, 0, 0, bub(nopz),    "hold_after_bubbles");
      applyStimulus(add_ind, 1, 0, 0, 0, cap(add_ind), "normal_after_bubbles");

      repeat (2) @(posedge clk_i);
      #2;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
`ifdef ID_EX_BUBBLE_CNT_EN
      // 17 bubbles since the last reset on a 4-bit counter leaves it at 1.
      tests++;
      if (BubbleCnt_o !== 4'd1) begin
         fails++;
         $display("[TB] FAIL bubble_wrap: got %0d expected 1", BubbleCnt_o);
      end
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
